amber128_mem_arbiter: RTL and testbench
=======================================

Name: amber128_mem_arbiter

Overview:
- Shares one 128-bit memory port between the instruction-fetch requester (16-byte bundle fetch) and the data requester (ld128/st128).
- Sits between fetch/execute and the single memory interface. Arbitrates, sequences one transaction at a time, and routes each response back to its owner.
- Data has default priority. A starvation limit guarantees fetch forward progress.

Parameters:
- ADDR_W, 64, byte-address width.
- DATA_W, 128, memory word width (= C_XLEN); must be 128.
- STARVE_LIMIT, 4, consecutive data wins while fetch waits before fetch is forced; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request; held stable until if_gnt_o
- if_addr_i  in  ADDR_W  fetch byte address
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch response valid (1-cycle pulse)
- if_rdata_o  out  DATA_W  fetch bundle
- d_req_i  in  1  data request; held stable until d_gnt_o
- d_we_i  in  1  1 = st128, 0 = ld128
- d_addr_i  in  ADDR_W  data byte address
- d_wdata_i  in  DATA_W  store data
- d_gnt_o  out  1  data request accepted (1-cycle pulse)
- d_rvalid_o  out  1  load data / store ack valid (1-cycle pulse)
- d_rdata_o  out  DATA_W  load data
- d_err_o  out  1  error qualifier, valid with d_rvalid_o
- m_req_o  out  1  memory request
- m_we_o  out  1  memory write enable
- m_addr_o  out  ADDR_W  memory address, bits [3:0] always 0
- m_wdata_o  out  DATA_W  memory write data
- m_gnt_i  in  1  memory accepted m_req_o
- m_rvalid_i  in  1  memory response
- m_rdata_i  in  DATA_W  memory read data
- m_err_i  in  1  memory error, valid with m_rvalid_i
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, state = IDLE, starve_cnt = 0, owner = fetch. Reset is asynchronous. Reset mid-transaction abandons it; no response is delivered.
- FSM states: IDLE, ISSUE, WAIT, ERR.
- IDLE:
  - Winner = data if d_req_i and not (if_req_i and starve_cnt == STARVE_LIMIT); otherwise fetch if if_req_i.
  - Winner's gnt_o is combinational in the same cycle. The arbiter latches addr, we, wdata and owner.
  - Data request with d_addr_i[3:0] != 0: gnt, no memory access, go to ERR.
  - Otherwise go to ISSUE. A fetch request has we = 0 and address bits [3:0] forced to 0.
- ISSUE: m_req_o, m_we_o, m_addr_o and m_wdata_o are registered and held constant until m_gnt_i. On m_gnt_i, go to WAIT and drop m_req_o on the next edge.
- WAIT: on m_rvalid_i, pulse the owner's rvalid_o in the same cycle (combinational route).
  - rdata_o carries m_rdata_i; d_err_o carries m_err_i for the data owner.
  - Go to IDLE. The next arbitration happens the following cycle.
  - A store completes with d_rvalid_o = 1 and d_rdata_o = 0.
  - m_err_i on a fetch response is dropped (fetch has no error port; trapping is the fetch unit's job via bounds).
- ERR: pulse d_rvalid_o = 1, d_err_o = 1, d_rdata_o = 0 for one cycle, then go to IDLE.
- starve_cnt (4-bit), updated at arbitration in IDLE:
  - Data wins while if_req_i = 1: increment.
  - Fetch wins: clear.
  - if_req_i = 0: clear.
  - Never exceeds STARVE_LIMIT.
- rdata_o is 0 on the non-owner port and whenever its rvalid is 0.
- m_rvalid_i or m_gnt_i in IDLE, ERR or an unexpected state is ignored.
- Minimum transaction: 3 cycles when gnt and rvalid each arrive one cycle after request.
- Simultaneous m_gnt_i and m_rvalid_i in ISSUE is illegal: the memory must respond at least one cycle after gnt.

Optional Feature:
- Macro AMBER128_MEM_ARB_PERF_EN.
- When defined, adds output perf_if_wait_o [31:0]: saturating count of cycles with if_req_i = 1 and if_gnt_o = 0. Reset to 0; holds at 32'hFFFF_FFFF.
- When undefined, the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Fetch alone: if_req_i = 1, if_addr_i = 0x1008; m_gnt_i after 1 cycle, m_rvalid_i with m_rdata_i = 0xA5..A5 after 2 more → m_addr_o = 0x1000, m_we_o = 0, if_rvalid_o pulses once with 0xA5..A5, d_rvalid_o stays 0.
- Contention: if_req_i and d_req_i both high in IDLE, starve_cnt = 0 → d_gnt_o first, if_gnt_o on the next IDLE; starve_cnt = 1 after the first arbitration.
- Starvation: d_req_i held high with back-to-back data transactions, if_req_i high, STARVE_LIMIT = 4 → 4 data grants, then if_gnt_o, then starve_cnt = 0.
- Store: d_we_i = 1, d_addr_i = 0x2000, d_wdata_i = 0x0123..EF → m_we_o = 1, m_wdata_o matches and is held through 3 cycles of m_gnt_i = 0; d_rvalid_o = 1, d_err_o = 0 on response.
- Misaligned load: d_addr_i = 0x2004 → d_gnt_o, m_req_o never asserted, next cycle d_rvalid_o = 1 and d_err_o = 1; memory error m_err_i = 1 on a valid load → d_err_o = 1.
- Reset mid-WAIT: assert rst_n = 0 in WAIT → outputs 0 immediately; m_rvalid_i after release produces no rvalid; with AMBER128_MEM_ARB_PERF_EN, perf_if_wait_o = 0 after reset.

Source files
------------

// File: rtl/amber128_mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of one 128-bit memory port, one transaction in flight.
// Optional build macro AMBER128_MEM_ARB_PERF_EN adds a saturating fetch-wait cycle counter.
module amber128_mem_arbiter #(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 128,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_err_o,
   output logic              m_req_o,
   output logic              m_we_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   input  logic              m_gnt_i,
   input  logic              m_rvalid_i,
   input  logic [DATA_W-1:0] m_rdata_i,
   input  logic              m_err_i,
`ifdef AMBER128_MEM_ARB_PERF_EN
   output logic [31:0]       perf_if_wait_o,
`endif
   output logic              busy_o
);

   // Handshakes: a requester holds req/addr/data stable until its gnt pulse; the memory
   // holds nothing, m_req_o stays up until m_gnt_i, and m_rvalid_i arrives after gnt.
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_starve_cnt;
   logic                r_owner_d;
   logic                r_we;
   logic                r_m_req;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                w_idle;
   logic                w_fetch_forced;
   logic                w_d_win;
   logic                w_if_win;
   logic                w_d_misalign;
   logic                w_unused_addr;

   assign w_idle         = (r_state == S_IDLE);
   assign w_fetch_forced = if_req_i && (r_starve_cnt == 4'(STARVE_LIMIT));
   // Gating with rst_n keeps the combinational grants low while reset is held.
   assign w_d_win        = rst_n && w_idle && d_req_i && !w_fetch_forced;
   assign w_if_win       = rst_n && w_idle && if_req_i && !w_d_win;
   assign w_d_misalign   = (d_addr_i[3:0] != 4'd0);
   assign w_unused_addr  = ^if_addr_i[3:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_d_win)       w_next = w_d_misalign ? S_ERR : S_ISSUE;
            else if (w_if_win) w_next = S_ISSUE;
         end
         S_ISSUE: if (m_gnt_i)    w_next = S_WAIT;
         S_WAIT:  if (m_rvalid_i) w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      if_gnt_o    = w_if_win;
      d_gnt_o     = w_d_win;
      if_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      d_rvalid_o  = 1'b0;
      d_rdata_o   = '0;
      d_err_o     = 1'b0;
      busy_o      = !w_idle;
      case (r_state)
         S_WAIT: begin
            if (m_rvalid_i) begin
               if (r_owner_d) begin
                  d_rvalid_o = 1'b1;
                  d_err_o    = m_err_i;
                  d_rdata_o  = r_we ? '0 : m_rdata_i;
               end else begin
                  if_rvalid_o = 1'b1;
                  if_rdata_o  = m_rdata_i;
               end
            end
         end
         S_ERR: begin
            d_rvalid_o = 1'b1;
            d_err_o    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner_d <= 1'b0;
         r_we      <= 1'b0;
         r_m_req   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
      end else if (w_d_win || w_if_win) begin
         r_owner_d <= w_d_win;
         r_we      <= w_d_win && d_we_i;
         r_addr    <= w_d_win ? {d_addr_i[ADDR_W-1:4], 4'b0000} : {if_addr_i[ADDR_W-1:4], 4'b0000};
         r_wdata   <= w_d_win ? d_wdata_i : '0;
         r_m_req   <= !(w_d_win && w_d_misalign);
      end else if (r_state == S_ISSUE && m_gnt_i) begin
         r_m_req   <= 1'b0;
      end
   end

   // Counts data wins that overtook a waiting fetch; cleared whenever fetch wins or stops asking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= 4'd0;
      end else if (w_idle) begin
         if (!if_req_i)
            r_starve_cnt <= 4'd0;
         else if (w_d_win && r_starve_cnt != 4'(STARVE_LIMIT))
            r_starve_cnt <= r_starve_cnt + 4'd1;
         else if (!w_d_win)
            r_starve_cnt <= 4'd0;
      end
   end

   assign m_req_o   = r_m_req;
   assign m_we_o    = r_we;
   assign m_addr_o  = r_addr;
   assign m_wdata_o = r_wdata;

`ifdef AMBER128_MEM_ARB_PERF_EN
   logic [31:0] r_perf_if_wait;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_perf_if_wait <= 32'd0;
      else if (if_req_i && !if_gnt_o && r_perf_if_wait != 32'hFFFF_FFFF)
         r_perf_if_wait <= r_perf_if_wait + 32'd1;
   end

   assign perf_if_wait_o = r_perf_if_wait;
`endif

endmodule

// File: tb/tb_amber128_mem_arbiter.sv
// Directed bench for amber128_mem_arbiter: inputs driven 1 time unit after posedge, outputs checked at negedge.
module tb_amber128_mem_arbiter;

   logic          clk;
   logic          rst_n;
   logic          if_req_i;
   logic [63:0]   if_addr_i;
   logic          if_gnt_o;
   logic          if_rvalid_o;
   logic [127:0]  if_rdata_o;
   logic          d_req_i;
   logic          d_we_i;
   logic [63:0]   d_addr_i;
   logic [127:0]  d_wdata_i;
   logic          d_gnt_o;
   logic          d_rvalid_o;
   logic [127:0]  d_rdata_o;
   logic          d_err_o;
   logic          m_req_o;
   logic          m_we_o;
   logic [63:0]   m_addr_o;
   logic [127:0]  m_wdata_o;
   logic          m_gnt_i;
   logic          m_rvalid_i;
   logic [127:0]  m_rdata_i;
   logic          m_err_i;
   logic          busy_o;
`ifdef AMBER128_MEM_ARB_PERF_EN
   logic [31:0]   perf_if_wait_o;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [127:0] ST_DATA = 128'h0123456789ABCDEF0123456789ABCDEF;

   amber128_mem_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_gnt_o    (if_gnt_o),
      .if_rvalid_o (if_rvalid_o),
      .if_rdata_o  (if_rdata_o),
      .d_req_i     (d_req_i),
      .d_we_i      (d_we_i),
      .d_addr_i    (d_addr_i),
      .d_wdata_i   (d_wdata_i),
      .d_gnt_o     (d_gnt_o),
      .d_rvalid_o  (d_rvalid_o),
      .d_rdata_o   (d_rdata_o),
      .d_err_o     (d_err_o),
      .m_req_o     (m_req_o),
      .m_we_o      (m_we_o),
      .m_addr_o    (m_addr_o),
      .m_wdata_o   (m_wdata_o),
      .m_gnt_i     (m_gnt_i),
      .m_rvalid_i  (m_rvalid_i),
      .m_rdata_i   (m_rdata_i),
      .m_err_i     (m_err_i),
`ifdef AMBER128_MEM_ARB_PERF_EN
      .perf_if_wait_o (perf_if_wait_o),
`endif
      .busy_o      (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      if_req_i = 1'b0; if_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
      m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0; m_err_i = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_if_gnt", if_gnt_o, 0);
      chk("rst_d_gnt", d_gnt_o, 0);
      chk("rst_d_rvalid", d_rvalid_o, 0);
      chk("rst_m_req", m_req_o, 0);
      chk("rst_m_addr", m_addr_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_starve", dut.r_starve_cnt, 0);
`ifdef AMBER128_MEM_ARB_PERF_EN
      chk("rst_perf", perf_if_wait_o, 0);
`endif
      nc();
      rst_n = 1'b1;

      // fetch alone
      if_req_i = 1'b1; if_addr_i = 64'h1008;
      @(negedge clk);
      chk("f_if_gnt", if_gnt_o, 1);
      chk("f_d_gnt", d_gnt_o, 0);
      nc();
      if_req_i = 1'b0; if_addr_i = '0; m_gnt_i = 1'b1;
      @(negedge clk);
      chk("f_m_req", m_req_o, 1);
      chk("f_m_addr", m_addr_o, 128'h1000);
      chk("f_m_we", m_we_o, 0);
      chk("f_busy", busy_o, 1);
      nc();
      m_gnt_i = 1'b0;
      @(negedge clk);
      chk("f_m_req_drop", m_req_o, 0);
      chk("f_early_rvalid", if_rvalid_o, 0);
      nc();
      m_rvalid_i = 1'b1; m_rdata_i = {16{8'hA5}};
      @(negedge clk);
      chk("f_if_rvalid", if_rvalid_o, 1);
      chk("f_if_rdata", if_rdata_o, {16{8'hA5}});
      chk("f_d_rvalid", d_rvalid_o, 0);
      chk("f_d_rdata", d_rdata_o, 0);
      nc();
      m_rvalid_i = 1'b0; m_rdata_i = '0;
      @(negedge clk);
      chk("f_if_rvalid_end", if_rvalid_o, 0);
      chk("f_if_rdata_end", if_rdata_o, 0);
      chk("f_busy_end", busy_o, 0);

      // contention then starvation: four data wins, then fetch is forced
      nc();
      if_req_i = 1'b1; if_addr_i = 64'h5000;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h3000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("s_d_gnt", d_gnt_o, 1);
         chk("s_if_gnt", if_gnt_o, 0);
         nc();
         m_gnt_i = 1'b1;
         @(negedge clk);
         chk("s_starve", dut.r_starve_cnt, 128'(i + 1));
         chk("s_m_addr", m_addr_o, 128'h3000);
         nc();
         m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 128'h77 + 128'(i);
         @(negedge clk);
         chk("s_d_rvalid", d_rvalid_o, 1);
         chk("s_d_rdata", d_rdata_o, 128'h77 + 128'(i));
         chk("s_if_rvalid", if_rvalid_o, 0);
         nc();
         m_rvalid_i = 1'b0; m_rdata_i = '0;
      end
      @(negedge clk);
      chk("s_forced_if_gnt", if_gnt_o, 1);
      chk("s_forced_d_gnt", d_gnt_o, 0);
      chk("s_starve_limit", dut.r_starve_cnt, 4);
`ifdef AMBER128_MEM_ARB_PERF_EN
      chk("s_perf", perf_if_wait_o, 12);
`endif
      nc();
      if_req_i = 1'b0; d_req_i = 1'b0; m_gnt_i = 1'b1;
      @(negedge clk);
      chk("s_starve_clear", dut.r_starve_cnt, 0);
      chk("s_fetch_addr", m_addr_o, 128'h5000);
      nc();
      m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 128'hF00D;
      @(negedge clk);
      chk("s_fetch_rvalid", if_rvalid_o, 1);
      chk("s_fetch_d_rvalid", d_rvalid_o, 0);
      nc();
      m_rvalid_i = 1'b0; m_rdata_i = '0;

      // store held through three stalled cycles
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'h2000; d_wdata_i = ST_DATA;
      @(negedge clk);
      chk("st_d_gnt", d_gnt_o, 1);
      nc();
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("st_m_req", m_req_o, 1);
         chk("st_m_we", m_we_o, 1);
         chk("st_m_wdata", m_wdata_o, ST_DATA);
         chk("st_m_addr", m_addr_o, 128'h2000);
         nc();
      end
      m_gnt_i = 1'b1;
      @(negedge clk);
      chk("st_m_req_gnt", m_req_o, 1);
      nc();
      m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 128'hDEAD_BEEF;
      @(negedge clk);
      chk("st_d_rvalid", d_rvalid_o, 1);
      chk("st_d_err", d_err_o, 0);
      chk("st_d_rdata", d_rdata_o, 0);
      chk("st_if_rvalid", if_rvalid_o, 0);
      nc();
      m_rvalid_i = 1'b0; m_rdata_i = '0;

      // misaligned load
      d_req_i = 1'b1; d_addr_i = 64'h2004;
      @(negedge clk);
      chk("mis_d_gnt", d_gnt_o, 1);
      chk("mis_m_req0", m_req_o, 0);
      nc();
      d_req_i = 1'b0; d_addr_i = '0;
      @(negedge clk);
      chk("mis_d_rvalid", d_rvalid_o, 1);
      chk("mis_d_err", d_err_o, 1);
      chk("mis_d_rdata", d_rdata_o, 0);
      chk("mis_m_req1", m_req_o, 0);
      nc();
      @(negedge clk);
      chk("mis_d_rvalid_end", d_rvalid_o, 0);
      chk("mis_busy_end", busy_o, 0);
      chk("mis_m_req2", m_req_o, 0);

      // load with memory error
      nc();
      d_req_i = 1'b1; d_addr_i = 64'h2010;
      @(negedge clk);
      chk("me_d_gnt", d_gnt_o, 1);
      nc();
      d_req_i = 1'b0; d_addr_i = '0; m_gnt_i = 1'b1;
      @(negedge clk);
      chk("me_m_addr", m_addr_o, 128'h2010);
      chk("me_m_we", m_we_o, 0);
      nc();
      m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_err_i = 1'b1; m_rdata_i = {16{8'h55}};
      @(negedge clk);
      chk("me_d_rvalid", d_rvalid_o, 1);
      chk("me_d_err", d_err_o, 1);
      chk("me_d_rdata", d_rdata_o, {16{8'h55}});
      nc();
      m_rvalid_i = 1'b0; m_err_i = 1'b0; m_rdata_i = '0;

      // reset in WAIT abandons the fetch
      if_req_i = 1'b1; if_addr_i = 64'h4000;
      @(negedge clk);
      chk("rw_if_gnt", if_gnt_o, 1);
      nc();
      if_req_i = 1'b0; if_addr_i = '0; m_gnt_i = 1'b1;
      nc();
      m_gnt_i = 1'b0;
      @(negedge clk);
      chk("rw_busy_wait", busy_o, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rw_busy_rst", busy_o, 0);
      chk("rw_m_req_rst", m_req_o, 0);
      chk("rw_m_addr_rst", m_addr_o, 0);
`ifdef AMBER128_MEM_ARB_PERF_EN
      chk("rw_perf_rst", perf_if_wait_o, 0);
`endif
      nc();
      rst_n = 1'b1; m_rvalid_i = 1'b1; m_rdata_i = 128'hBAD;
      @(negedge clk);
      chk("rw_if_rvalid", if_rvalid_o, 0);
      chk("rw_if_rdata", if_rdata_o, 0);
      chk("rw_d_rvalid", d_rvalid_o, 0);
      chk("rw_busy", busy_o, 0);
      nc();
      m_rvalid_i = 1'b0; m_rdata_i = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
